// File: rtl/return_addr_stack_pkg.sv
// Shared defaults and full-stack push policy encodings for the return address stack.
package return_addr_stack_pkg;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 4;
    localparam int OVF_REJECT = 0;
    localparam int OVF_WRAP   = 1;
endpackage

// File: rtl/return_addr_stack_if.sv
// Call/return request bus and stack status; master drives requests, slave owns the stack.
interface return_addr_stack_if #(
    parameter int ADDR_W = return_addr_stack_pkg::DEF_ADDR_W,
    parameter int DEPTH  = return_addr_stack_pkg::DEF_DEPTH
);
    localparam int CW = $clog2(DEPTH + 1);

    logic              push_en;
    logic              pop_en;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] top_addr;
    logic [CW-1:0]     count;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output push_en, pop_en, push_addr,
        input  top_addr, count, empty, full, overflow, underflow
    );
    modport slave (
        input  push_en, pop_en, push_addr,
        output top_addr, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return address stack: sp addresses the top entry, count tracks occupancy.
module return_addr_stack
    import return_addr_stack_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int OVF_MODE = OVF_REJECT
) (
    input  logic                clk,
    input  logic                rst,
    return_addr_stack_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_sp;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_empty;
    logic              w_full;
    logic [PW-1:0]     w_sp_inc;
    logic [PW-1:0]     w_sp_dec;
    logic              w_push_only;
    logic              w_replace;
    logic              w_pop_only;
    logic              w_wr_en;
    logic [PW-1:0]     w_wr_idx;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));

    // Explicit compares so non-power-of-two depths wrap correctly
    assign w_sp_inc = (r_sp == PW'(DEPTH - 1)) ? '0 : r_sp + 1'b1;
    assign w_sp_dec = (r_sp == '0) ? PW'(DEPTH - 1) : r_sp - 1'b1;

    // A simultaneous push/pop on an empty stack degrades to a plain push
    assign w_push_only = bus.push_en && (!bus.pop_en || w_empty);
    assign w_replace   = bus.push_en && bus.pop_en && !w_empty;
    assign w_pop_only  = bus.pop_en && !bus.push_en;

    assign w_wr_en  = !rst && (w_replace ||
                      (w_push_only && (!w_full || OVF_MODE == OVF_WRAP)));
    assign w_wr_idx = w_replace ? r_sp : w_sp_inc;

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_idx] <= bus.push_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= w_push_only && w_full;
            r_underflow <= bus.pop_en && w_empty;
            if (w_push_only) begin
                if (!w_full) begin
                    r_sp    <= w_sp_inc;
                    r_count <= r_count + 1'b1;
                end else if (OVF_MODE == OVF_WRAP) begin
                    r_sp    <= w_sp_inc;
                end
            end else if (w_pop_only && !w_empty) begin
                r_sp    <= w_sp_dec;
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign bus.top_addr  = w_empty ? '0 : r_mem[r_sp];
    assign bus.count     = r_count;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
endmodule

// File: doc/return_addr_stack.md
RETURN_ADDR_STACK -- requirements
Module: return_addr_stack

Interface
REQ-001 Parameter ADDR_W, default 8, shall set the width of each stored return address.
REQ-002 Parameter DEPTH, default 4, shall set the number of stack entries; legal range 2..64.
REQ-003 Parameter OVF_MODE, default 0, shall select the full-stack push policy: 0 = reject push, 1 = overwrite oldest entry.
REQ-004 clk  input  1  shall be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  shall be the reset: synchronous, active-high.
REQ-006 push_en  input  1  shall request a push (CALL: store PC+1).
REQ-007 pop_en  input  1  shall request a pop (RET: release top for PC load).
REQ-008 push_addr  input  ADDR_W  shall carry the address to push.
REQ-009 top_addr  output  ADDR_W  shall present the current top-of-stack entry.
REQ-010 count  output  CW = clog2(DEPTH+1)  shall present the number of valid entries.
REQ-011 empty  output  1  shall be high when count = 0.
REQ-012 full  output  1  shall be high when count = DEPTH.
REQ-013 overflow  output  1  shall be a one-cycle registered pulse flagging a push while full.
REQ-014 underflow  output  1  shall be a one-cycle registered pulse flagging a pop while empty.

Function
REQ-015 Storage shall be a DEPTH x ADDR_W array indexed by a circular top pointer sp (clog2(DEPTH) bits) plus count.
REQ-016 top_addr shall be combinational from the array at the top entry, zero when empty.
REQ-017 Push only, not full: the entry at sp+1 (mod DEPTH) <= push_addr, sp advances, count+1; visible on top_addr the cycle after the edge.
REQ-018 Pop only, not empty: sp retreats (mod DEPTH), count-1; the popped value is top_addr in the cycle pop_en is sampled (zero-latency read, the PC loads it on the same edge).
REQ-019 Push and pop together, not empty: top entry <= push_addr; sp and count unchanged (RET followed by CALL/tail-call).
REQ-020 Push and pop together, empty: behave as push only; underflow pulses.
REQ-021 Push only, full, OVF_MODE=0: no state change; overflow pulses.
REQ-022 Push only, full, OVF_MODE=1: write at sp+1 overwriting oldest, sp advances, count stays DEPTH; overflow pulses.
REQ-023 Pop only, empty: no state change; underflow pulses; top_addr stays zero.
REQ-024 With neither request, all state shall hold.
REQ-025 Pointer arithmetic shall wrap modulo DEPTH for non-power-of-two DEPTH (explicit compare, not bit truncation).
REQ-026 count shall never exceed DEPTH nor go below 0.

Reset
REQ-027 While rst is high at a clock edge: sp=0, count=0, overflow=0, underflow=0, so empty=1, full=0, top_addr=0; rst overrides simultaneous push/pop.
REQ-028 Array contents need not be cleared; they shall be unobservable until rewritten.
REQ-029 Reset asserted mid-sequence shall discard all entries in one cycle.

Structure
REQ-030 A shared package shall hold default ADDR_W/DEPTH and the OVF_MODE encodings (OVF_REJECT=0, OVF_WRAP=1).
REQ-031 No sub-module is required; the array and pointer logic shall stay in one module.

Verification (ADDR_W=8, DEPTH=4)
REQ-032 Reset, then push 0x10,0x20,0x30 -> count=3, top_addr=0x30; three pops return 0x30,0x20,0x10, then empty=1.
REQ-033 OVF_MODE=0: push 0x01..0x04, then push 0x05 -> overflow pulse one cycle, top_addr=0x04, count=4; four pops return 04,03,02,01.
REQ-034 OVF_MODE=1: push 0x01..0x05 -> overflow pulse, count=4; pops return 05,04,03,02, then empty.
REQ-035 Stack holding 0x10,0x20: push 0x55 with pop -> count=2, top_addr=0x55; pop -> top_addr=0x10.
REQ-036 Empty stack: pop -> underflow pulse, count=0; push 0x7F with pop -> underflow pulse, count=1, top_addr=0x7F.
REQ-037 Push 0xAA,0xBB, assert rst with push 0xCC -> count=0, empty=1, top_addr=0x00, no flag pulses.
